vsm_in_register: RTL and testbench

//  Input-side counterpart of the VSM output register: captures a nibble from external

---
 rtl/vsm_in_register_if.sv | 43 ++++
 rtl/vsm_in_register.sv | 90 +++++++++
 tb/tb_vsm_in_register.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/vsm_in_register_if.sv
// vsm_in_register_if
//   Groups the pin-side and bus-side signals of the VSM input register.
//   The master modport is the environment (external device plus controller).
//   The slave modport is the register itself.
//
// Signals
//   In        device -> reg   data pins, sampled on the push cycle
//   InStrobe  device -> reg   asynchronous strobe; a rising edge means new data
//   ReadIn    ctrl   -> reg   read request, synchronous to MainClock
//   ClrErr    ctrl   -> reg   clears the sticky Overrun flag
//   IB_out    reg    -> bus   FIFO head while IB_oe=1, otherwise 0
//   IB_oe     reg    -> bus   bus drive enable
//   InReady   reg    -> ctrl  FIFO not empty (registered)
//   Overrun   reg    -> ctrl  sticky flag: a strobe arrived while the FIFO was full
//   Count     reg    -> ctrl  number of entries held
//
// Handshake: a read completes at the rising clock edge that ends a cycle in
// which IB_oe=1. IB_oe is ReadIn qualified by InReady. ReadIn while empty is
// ignored.
interface vsm_in_register_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
);
  logic [WIDTH-1:0]         In;
  logic                     InStrobe;
  logic                     ReadIn;
  logic                     ClrErr;
  logic [WIDTH-1:0]         IB_out;
  logic                     IB_oe;
  logic                     InReady;
  logic                     Overrun;
  logic [$clog2(DEPTH):0]   Count;

  modport master (
    output In, InStrobe, ReadIn, ClrErr,
    input  IB_out, IB_oe, InReady, Overrun, Count
  );

  modport slave (
    input  In, InStrobe, ReadIn, ClrErr,
    output IB_out, IB_oe, InReady, Overrun, Count
  );
endinterface

// File: rtl/vsm_in_register.sv
// vsm_in_register
//   Captures a nibble from external pins on an asynchronous strobe. The
//   nibble is queued in a small circular FIFO. It is driven onto the internal
//   bus IB when the controller asserts ReadIn.
//
// Ports
//   MainClock     system clock; all state updates on its rising edge
//   invMainReset  synchronous reset, active low
//   bus           vsm_in_register_if.slave (pins, read request, bus, status)
module vsm_in_register #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              MainClock,
  input  logic              invMainReset,
  vsm_in_register_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   in_ready_q, in_ready_d;
  logic                   overrun_q, overrun_d;

  logic push_req, full, pop, push, overrun_set, ib_oe;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], bus.InStrobe};
    // One request per strobe rise, however long the strobe stays high.
    push_req    = sync_q[SYNC_STAGES-1] & ~edge_q;
    full        = (count_q == CW'(DEPTH));
    pop         = bus.ReadIn & in_ready_q;
    // A full FIFO still accepts a push when a pop frees a slot at the same edge.
    push        = push_req & (~full | pop);
    overrun_set = push_req & full & ~pop;

    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != '0);

    // A new overrun takes priority over a clear in the same cycle.
    overrun_d = overrun_q;
    if (overrun_set)     overrun_d = 1'b1;
    else if (bus.ClrErr) overrun_d = 1'b0;
  end

  always_ff @(posedge MainClock) begin
    if (!invMainReset) begin
      sync_q     <= '0;
      edge_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync_q     <= sync_d;
      edge_q     <= sync_q[SYNC_STAGES-1];
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      overrun_q  <= overrun_d;
      if (push) mem_q[wr_ptr_q] <= bus.In;
    end
  end

  assign ib_oe       = bus.ReadIn & in_ready_q;
  assign bus.IB_oe   = ib_oe;
  assign bus.IB_out  = ib_oe ? mem_q[rd_ptr_q] : '0;
  assign bus.InReady = in_ready_q;
  assign bus.Overrun = overrun_q;
  assign bus.Count   = count_q;

endmodule

// File: tb/tb_vsm_in_register.sv
// tb_vsm_in_register
//   Directed scenarios followed by randomized traffic for vsm_in_register.
//   The reference model treats the FIFO as a plain queue. Every strobe rise
//   becomes a pending push that lands SYNC_STAGES edges later. Accepted data
//   goes into exp_q. A negedge monitor pops exp_q whenever the DUT drives the
//   bus, and it compares the status outputs every cycle.
module tb_vsm_in_register;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int SYNC  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vsm_in_register_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bif ();

  vsm_in_register #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .MainClock    (clk),
    .invMainReset (rst_n),
    .bus          (bif.slave)
  );

  // ---------------- counters / scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] exp_q[$];

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] fifo_m[$];
  int  pend_m[$];
  int  cyc = 0;
  bit  prev_strobe = 1'b0;
  bit  ovr_m = 1'b0;
  bit  mon_en = 1'b0;

  always @(posedge clk) begin
    bit did_pop, was_full, set_ovr;
    cyc++;
    if (!rst_n) begin
      fifo_m.delete();
      pend_m.delete();
      exp_q.delete();
      ovr_m = 1'b0;
      prev_strobe = 1'b0;
    end else begin
      was_full = (fifo_m.size() == DEPTH);
      did_pop  = bif.ReadIn && (fifo_m.size() > 0);
      set_ovr  = 1'b0;
      if (did_pop) void'(fifo_m.pop_front());
      while (pend_m.size() > 0 && pend_m[0] == cyc) begin
        void'(pend_m.pop_front());
        if (was_full && !did_pop) set_ovr = 1'b1;
        else begin
          fifo_m.push_back(bif.In);
          exp_q.push_back(bif.In);
        end
      end
      if (set_ovr) ovr_m = 1'b1;
      else if (bif.ClrErr) ovr_m = 1'b0;
      if (bif.InStrobe && !prev_strobe) pend_m.push_back(cyc + SYNC);
      prev_strobe = bif.InStrobe;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_oe;
      exp_oe = bif.ReadIn && (fifo_m.size() > 0);
      chk("count",    int'(bif.Count),   fifo_m.size());
      chk("in_ready", int'(bif.InReady), int'(fifo_m.size() > 0));
      chk("overrun",  int'(bif.Overrun), int'(ovr_m));
      chk("ib_oe",    int'(bif.IB_oe),   int'(exp_oe));
      if (bif.IB_oe === 1'b1) begin
        if (exp_q.size() == 0) chk("ib_underflow", 1, 0);
        else chk("ib_out", int'(bif.IB_out), int'(exp_q.pop_front()));
      end else begin
        chk("ib_out_idle", int'(bif.IB_out), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input bit rd);
    bif.In = d;
    bif.InStrobe = 1'b1;
    bif.ReadIn = rd;
    repeat (2) tick();
    bif.InStrobe = 1'b0;
    repeat (SYNC) tick();
    bif.ReadIn = 1'b0;
  endtask

  task automatic read1();
    bif.ReadIn = 1'b1;
    tick();
    bif.ReadIn = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && fifo_m.size() > 0; i++) read1();
    chk("drain_count", int'(bif.Count), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bif.In = '0;
    bif.InStrobe = 1'b0;
    bif.ReadIn = 1'b0;
    bif.ClrErr = 1'b0;

    // 1: reset with the strobe toggling
    rst_n = 1'b0;
    bif.InStrobe = 1'b1;
    tick();
    mon_en = 1'b1;
    bif.InStrobe = 1'b0;
    tick();
    bif.InStrobe = 1'b1;
    tick();
    bif.InStrobe = 1'b0;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_reset_count", int'(bif.Count), 0);

    // 2: single transfer
    send(4'hA, 1'b0);
    chk("single_ready", int'(bif.InReady), 1);
    read1();
    chk("single_empty", int'(bif.Count), 0);

    // 3: ordering and pointer wrap
    send(4'h3, 1'b0);
    send(4'h5, 1'b0);
    read1();
    send(4'h9, 1'b0);
    read1();
    send(4'hC, 1'b0);
    drain();

    // 4: overrun, then clear
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h7, 1'b0);
    chk("ovr_set", int'(bif.Overrun), 1);
    drain();
    bif.ClrErr = 1'b1;
    tick();
    bif.ClrErr = 1'b0;
    chk("ovr_clr", int'(bif.Overrun), 0);

    // 5: push and pop at the same edge while full
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    bif.In = 4'h4;
    bif.InStrobe = 1'b1;
    repeat (SYNC) tick();
    bif.ReadIn = 1'b1;
    tick();
    bif.ReadIn = 1'b0;
    bif.InStrobe = 1'b0;
    tick();
    chk("simul_count", int'(bif.Count), 2);
    drain();

    // 6: read while empty, and a long strobe
    read1();
    bif.In = 4'h6;
    bif.InStrobe = 1'b1;
    repeat (20) tick();
    bif.InStrobe = 1'b0;
    repeat (4) tick();
    chk("long_strobe_count", int'(bif.Count), 1);
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 49);
      bif.ClrErr = ($urandom_range(0, 7) == 0);
      if (op == 0) begin
        bif.InStrobe = 1'b0;
        bif.ReadIn = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
      end else if (op < 25) begin
        send(WIDTH'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
      end else if (op < 40) begin
        read1();
      end else begin
        tick();
      end
      bif.ClrErr = 1'b0;
    end
    bif.ClrErr = 1'b0;
    repeat (SYNC + 2) tick();
    drain();
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time limit; the stimulus ends far earlier.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
